// File: rtl/vga_scan_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scan_engine : VGA H/V raster timing, frame-buffer read addressing    |
// |                   with pixel replication, latency-aligned sync/colour    |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module vga_scan_engine #(
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int SCALE  = 0,
  parameter int RD_LAT = 1,
  parameter int CW     = 4,
  parameter int ADDR_W = 19
) (
  input  logic              vga_clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pic_addr,
  output logic              pic_rd_en,
  input  logic [3*CW-1:0]   vga_color,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [CW-1:0]     vga_color_red,
  output logic [CW-1:0]     vga_color_green,
  output logic [CW-1:0]     vga_color_blue,
  output logic              frame_start
);

  localparam int c_H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int c_V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int c_H_W   = $clog2(c_H_TOT);
  localparam int c_V_W   = $clog2(c_V_TOT);
  localparam int c_SC_W  = (SCALE == 0) ? 1 : SCALE;
  localparam int c_DLY   = RD_LAT + 2;

  localparam logic [c_H_W-1:0] c_H_LAST = c_H_W'(c_H_TOT - 1);
  localparam logic [c_H_W-1:0] c_H_SYNC = c_H_W'(H_SYNC);
  localparam logic [c_H_W-1:0] c_H_AS   = c_H_W'(H_SYNC + H_BP);
  localparam logic [c_H_W-1:0] c_H_AE   = c_H_W'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [c_V_W-1:0] c_V_LAST = c_V_W'(c_V_TOT - 1);
  localparam logic [c_V_W-1:0] c_V_SYNC = c_V_W'(V_SYNC);
  localparam logic [c_V_W-1:0] c_V_AS   = c_V_W'(V_SYNC + V_BP);
  localparam logic [c_V_W-1:0] c_V_AE   = c_V_W'(V_SYNC + V_BP + V_ACT - 1);

  localparam logic [c_SC_W-1:0] c_SUB_MAX = c_SC_W'((1 << SCALE) - 1);
  localparam logic [ADDR_W-1:0] c_SRC_W   = ADDR_W'(H_ACT >> SCALE);
  localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);

  // Delay-line word layout: {frame_start, de, vs, hs}
  localparam logic [3:0] c_IDLE = {2'b00, ~VS_POL, ~HS_POL};

  generate
    if ((longint'(H_ACT >> SCALE) * longint'(V_ACT >> SCALE)) > (longint'(1) << ADDR_W)) begin : g_err_addr
      $error("vga_scan_engine: source image does not fit in ADDR_W address bits");
    end
    if (((H_ACT % (1 << SCALE)) != 0) || ((V_ACT % (1 << SCALE)) != 0)) begin : g_err_scale
      $error("vga_scan_engine: H_ACT/V_ACT must be multiples of the replication factor");
    end
    if ((SCALE < 0) || (SCALE > 2)) begin : g_err_scale_rng
      $error("vga_scan_engine: SCALE must be 0, 1 or 2");
    end
    if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_err_lat
      $error("vga_scan_engine: RD_LAT must be 1..4");
    end
  endgenerate

  logic [c_H_W-1:0]  r_h_cnt;
  logic [c_V_W-1:0]  r_v_cnt;
  logic [c_SC_W-1:0] r_col_sub;
  logic [c_SC_W-1:0] r_row_sub;
  logic [ADDR_W-1:0] r_src_x;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_pic_addr;
  logic              r_pic_rd_en;
  logic [3:0]        r_dly [c_DLY];
  logic [3*CW-1:0]   r_rgb;

  logic w_h_wrap;
  logic w_frame_wrap;
  logic w_h_act;
  logic w_v_act;
  logic w_act;
  logic w_hs;
  logic w_vs;
  logic w_first;
  logic [3:0] w_raw;

  always_comb begin
    w_h_wrap     = (r_h_cnt == c_H_LAST);
    w_frame_wrap = w_h_wrap && (r_v_cnt == c_V_LAST);
    w_h_act      = (r_h_cnt >= c_H_AS) && (r_h_cnt <= c_H_AE);
    w_v_act      = (r_v_cnt >= c_V_AS) && (r_v_cnt <= c_V_AE);
    w_act        = w_h_act && w_v_act;
    w_hs         = (r_h_cnt < c_H_SYNC) ? HS_POL : ~HS_POL;
    w_vs         = (r_v_cnt < c_V_SYNC) ? VS_POL : ~VS_POL;
    w_first      = (r_h_cnt == c_H_AS) && (r_v_cnt == c_V_AS);
    w_raw        = {w_first, w_act, w_vs, w_hs};
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_V_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + c_H_W'(1);
    end
  end

  // Address walk without a multiplier: the sub-counters hold each source
  // pixel/line for 1<<SCALE output pixels/lines.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_col_sub <= '0;
      r_row_sub <= '0;
      r_src_x   <= '0;
      r_base    <= '0;
    end else begin
      if (w_act) begin
        if (r_col_sub == c_SUB_MAX) begin
          r_col_sub <= '0;
          r_src_x   <= r_src_x + c_ONE;
        end else begin
          r_col_sub <= r_col_sub + c_SC_W'(1);
        end
        if (r_h_cnt == c_H_AE) begin
          r_col_sub <= '0;
          r_src_x   <= '0;
          if (r_row_sub == c_SUB_MAX) begin
            r_row_sub <= '0;
            r_base    <= r_base + c_SRC_W;
          end else begin
            r_row_sub <= r_row_sub + c_SC_W'(1);
          end
        end
      end
      if (w_frame_wrap) begin
        r_col_sub <= '0;
        r_row_sub <= '0;
        r_src_x   <= '0;
        r_base    <= '0;
      end
    end
  end

  // The address is left untouched outside the active window.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_pic_addr  <= '0;
      r_pic_rd_en <= 1'b0;
    end else begin
      r_pic_rd_en <= w_act;
      if (w_act) begin
        r_pic_addr <= r_base + r_src_x;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < c_DLY; k++) begin
        r_dly[k] <= c_IDLE;
      end
      r_rgb <= '0;
    end else begin
      r_dly[0] <= w_raw;
      for (int k = 1; k < c_DLY; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
      // Stage RD_LAT carries the de belonging to the pixel now on vga_color.
      r_rgb <= r_dly[RD_LAT][2] ? vga_color : '0;
    end
  end

  assign pic_addr        = r_pic_addr;
  assign pic_rd_en       = r_pic_rd_en;
  assign hs              = r_dly[c_DLY-1][0];
  assign vs              = r_dly[c_DLY-1][1];
  assign de              = r_dly[c_DLY-1][2];
  assign frame_start     = r_dly[c_DLY-1][3];
  assign vga_color_red   = r_rgb[3*CW-1:2*CW];
  assign vga_color_green = r_rgb[2*CW-1:CW];
  assign vga_color_blue  = r_rgb[CW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_scan_engine : four engine configurations against a raster model   |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_vga_scan_engine;

  localparam int NI = 4;
  localparam int P_HS [NI] = '{4, 4, 4, 96};
  localparam int P_HB [NI] = '{3, 3, 3, 48};
  localparam int P_HA [NI] = '{8, 8, 8, 640};
  localparam int P_HF [NI] = '{2, 2, 2, 16};
  localparam int P_VS [NI] = '{2, 2, 2, 2};
  localparam int P_VB [NI] = '{2, 2, 2, 33};
  localparam int P_VA [NI] = '{8, 8, 8, 480};
  localparam int P_VF [NI] = '{1, 1, 1, 10};
  localparam int P_HP [NI] = '{0, 1, 0, 0};
  localparam int P_VP [NI] = '{0, 1, 1, 0};
  localparam int P_SC [NI] = '{0, 1, 2, 0};
  localparam int P_LT [NI] = '{1, 3, 4, 1};

  logic        clk;
  logic        rst;
  logic [18:0] pa   [NI];
  logic        re   [NI];
  logic [11:0] cin  [NI];
  logic        hs   [NI];
  logic        vs   [NI];
  logic        de   [NI];
  logic [3:0]  cr   [NI];
  logic [3:0]  cg   [NI];
  logic [3:0]  cb   [NI];
  logic        fs   [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_scan_engine #(.H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2), .V_SYNC(2), .V_BP(2), .V_ACT(8),
    .V_FP(1), .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(0), .RD_LAT(1), .CW(4), .ADDR_W(19)) u_d0 (
    .vga_clk(clk), .rst(rst), .pic_addr(pa[0]), .pic_rd_en(re[0]), .vga_color(cin[0]),
    .hs(hs[0]), .vs(vs[0]), .de(de[0]), .vga_color_red(cr[0]), .vga_color_green(cg[0]),
    .vga_color_blue(cb[0]), .frame_start(fs[0]));

  vga_scan_engine #(.H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2), .V_SYNC(2), .V_BP(2), .V_ACT(8),
    .V_FP(1), .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(1), .RD_LAT(3), .CW(4), .ADDR_W(19)) u_d1 (
    .vga_clk(clk), .rst(rst), .pic_addr(pa[1]), .pic_rd_en(re[1]), .vga_color(cin[1]),
    .hs(hs[1]), .vs(vs[1]), .de(de[1]), .vga_color_red(cr[1]), .vga_color_green(cg[1]),
    .vga_color_blue(cb[1]), .frame_start(fs[1]));

  vga_scan_engine #(.H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2), .V_SYNC(2), .V_BP(2), .V_ACT(8),
    .V_FP(1), .HS_POL(1'b0), .VS_POL(1'b1), .SCALE(2), .RD_LAT(4), .CW(4), .ADDR_W(19)) u_d2 (
    .vga_clk(clk), .rst(rst), .pic_addr(pa[2]), .pic_rd_en(re[2]), .vga_color(cin[2]),
    .hs(hs[2]), .vs(vs[2]), .de(de[2]), .vga_color_red(cr[2]), .vga_color_green(cg[2]),
    .vga_color_blue(cb[2]), .frame_start(fs[2]));

  vga_scan_engine u_d3 (
    .vga_clk(clk), .rst(rst), .pic_addr(pa[3]), .pic_rd_en(re[3]), .vga_color(cin[3]),
    .hs(hs[3]), .vs(vs[3]), .de(de[3]), .vga_color_red(cr[3]), .vga_color_green(cg[3]),
    .vga_color_blue(cb[3]), .frame_start(fs[3]));

  // Frame-buffer model: word at address a holds a[11:0]; garbage when not strobed.
  logic [18:0] ap   [NI][4];
  logic        ep   [NI][4];
  logic [11:0] junk [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      ap[i][0] <= pa[i];
      ep[i][0] <= re[i];
      for (int k = 1; k < 4; k++) begin
        ap[i][k] <= ap[i][k-1];
        ep[i][k] <= ep[i][k-1];
      end
      junk[i] <= 12'($urandom);
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      cin[i] = ep[i][P_LT[i]-1] ? ap[i][P_LT[i]-1][11:0] : junk[i];
    end
  end

  task automatic chk(input string nm, input int i, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s inst%0d n=%0d: got %0d expected %0d", nm, i, n, got, exp);
    end
  endtask

  // Raster position of counter state s, and the source pixel it maps to.
  task automatic pix(input int i, input int s, output bit act, output bit hx, output bit vx,
                     output bit fx, output int addr);
    int htot, vtot, h, v, x, y;
    htot = P_HS[i] + P_HB[i] + P_HA[i] + P_HF[i];
    vtot = P_VS[i] + P_VB[i] + P_VA[i] + P_VF[i];
    h    = s % htot;
    v    = (s / htot) % vtot;
    x    = h - (P_HS[i] + P_HB[i]);
    y    = v - (P_VS[i] + P_VB[i]);
    act  = (x >= 0) && (x < P_HA[i]) && (y >= 0) && (y < P_VA[i]);
    hx   = (h < P_HS[i]) ? (P_HP[i] == 1) : (P_HP[i] == 0);
    vx   = (v < P_VS[i]) ? (P_VP[i] == 1) : (P_VP[i] == 0);
    fx   = act && (x == 0) && (y == 0);
    addr = act ? ((y >> P_SC[i]) * (P_HA[i] >> P_SC[i]) + (x >> P_SC[i])) : 0;
  endtask

  int exp_addr [NI];

  always @(negedge clk) begin
    bit act, hx, vx, fx;
    int a, s2;
    if (!rst) begin
      n = 0;
      for (int i = 0; i < NI; i++) begin
        exp_addr[i] = 0;
        chk("rst_rd_en", i, re[i], 0);
        chk("rst_addr", i, pa[i], 0);
        chk("rst_hs", i, hs[i], (P_HP[i] == 0) ? 1 : 0);
        chk("rst_vs", i, vs[i], (P_VP[i] == 0) ? 1 : 0);
        chk("rst_de", i, de[i], 0);
        chk("rst_rgb", i, {cr[i], cg[i], cb[i]}, 0);
        chk("rst_fs", i, fs[i], 0);
      end
    end else begin
      n++;
      for (int i = 0; i < NI; i++) begin
        pix(i, n - 1, act, hx, vx, fx, a);
        if (act) exp_addr[i] = a;
        chk("rd_en", i, re[i], act);
        chk("addr", i, pa[i], exp_addr[i]);
        s2 = n - (P_LT[i] + 2);
        if (s2 < 0) begin
          act = 1'b0; fx = 1'b0; a = 0;
          hx = (P_HP[i] == 0); vx = (P_VP[i] == 0);
        end else begin
          pix(i, s2, act, hx, vx, fx, a);
        end
        chk("hs", i, hs[i], hx);
        chk("vs", i, vs[i], vx);
        chk("de", i, de[i], act);
        chk("rgb", i, {cr[i], cg[i], cb[i]}, act ? (a & 12'hFFF) : 0);
        chk("frame_start", i, fs[i], fx);
      end
      // Hand-computed anchors for the small raster (17 x 13) and the default one.
      if (n == 2)     chk("lit_hs_reset_i0", 0, hs[0], 1);
      if (n == 3)     chk("lit_hs_first_i0", 0, hs[0], 0);
      if (n == 4)     chk("lit_hs_reset_i1", 1, hs[1], 0);
      if (n == 5)     chk("lit_hs_first_i1", 1, hs[1], 1);
      if (n == 9)     chk("lit_hs_end_i1", 1, hs[1], 0);
      if (n == 75)    chk("lit_rd_pre_i0", 0, re[0], 0);
      if (n == 76) begin
        chk("lit_rd_first_i0", 0, re[0], 1);
        chk("lit_addr_first_i0", 0, pa[0], 0);
      end
      if (n == 78) begin
        chk("lit_de_first_i0", 0, de[0], 1);
        chk("lit_fs_first_i0", 0, fs[0], 1);
      end
      if (n == 79)    chk("lit_blue_px1_i0", 0, cb[0], 1);
      if (n == 110)   chk("lit_line6_i1", 1, pa[1], 4);
      if (n == 127)   chk("lit_line7_i2", 2, pa[2], 0);
      if (n == 144)   chk("lit_line8_i2", 2, pa[2], 2);
      if (n == 202) begin
        chk("lit_last_i0", 0, pa[0], 63);
        chk("lit_last_i1", 1, pa[1], 15);
        chk("lit_last_i2", 2, pa[2], 3);
      end
      if (n == 299)   chk("lit_fs_frame2_i0", 0, fs[0], 1);
      if (n == 28144) chk("lit_rd_pre_dflt", 3, re[3], 0);
      if (n == 28145) begin
        chk("lit_rd_first_dflt", 3, re[3], 1);
        chk("lit_addr_first_dflt", 3, pa[3], 0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (28200) @(negedge clk);
    // Mid-frame reset: outputs must fall back immediately, not at the next edge.
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rd_en", i, re[i], 0);
      chk("async_addr", i, pa[i], 0);
      chk("async_hs", i, hs[i], (P_HP[i] == 0) ? 1 : 0);
      chk("async_vs", i, vs[i], (P_VP[i] == 0) ? 1 : 0);
      chk("async_de", i, de[i], 0);
    end
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    repeat (450) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
